// File: rtl/rom_stream_reader_if.sv
// rtl/rom_stream_reader_if.sv - ROM access and output stream signals of the reader
// master: the reader; slave: the ROM plus the downstream consumer.
interface rom_stream_reader_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output rom_addr,
    input  rom_data,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );
endinterface

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - walks a ROM address range and streams the words out
// Reads are issued only when the 2-entry FIFO is sure to have room for the returning word.
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  rom_stream_reader_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];
  logic [1:0]            fifo_last_q, fifo_last_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  logic                  pop;
  logic [2:0]            occ;

  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = bus.out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.out_last  = bus.out_valid & fifo_last_q[rd_ptr_q];
  assign bus.rom_addr  = rom_addr_d;
  assign busy          = busy_q;
  assign done          = done_q;

  assign pop = bus.out_valid && bus.out_ready;
  // Slots that will be taken after this edge if nothing new is issued.
  assign occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remain_d        = remain_q;
    rom_addr_d      = rom_addr_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    busy_d          = busy_q & ~done_q;
    done_d          = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = length;
          busy_d   = 1'b1;
          state_d  = (length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (occ < 3'd2) begin
          rom_addr_d      = addr_q;
          addr_d          = addr_q + ADDR_ONE;
          remain_d        = remain_q - LEN_ONE;
          inflight_d      = 1'b1;
          inflight_last_d = (remain_q == LEN_ONE);
          if (remain_q == LEN_ONE) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && bus.out_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Word read last cycle lands in the FIFO now; its last flag travels with it.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (inflight_q) begin
      fifo_data_d[wr_ptr_q] = bus.rom_data;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      rom_addr_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      fifo_data_q     <= '{default: '0};
      fifo_last_q     <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      rom_addr_q      <= rom_addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(inflight_q && (count_q == 2'd2) && !pop));

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb/tb_rom_stream_reader.sv - directed bench for rom_stream_reader against a data[a]=a ROM
module tb_rom_stream_reader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] base_addr;
  logic [3:0] length;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  rom_stream_reader_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

  rom_stream_reader #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data[a] = a, one cycle read latency.
  always @(posedge clk) bus.rom_data <= {5'b00000, bus.rom_addr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one transfer; exp_beats holds expected bytes, beat 0 in the low byte.
  // exp_first / exp_done are cycle numbers after the start edge (-1 = not checked).
  task automatic xfer(input string tag, input logic [2:0] base, input logic [3:0] len,
                      input bit bp_mode, input logic [63:0] exp_beats,
                      input int exp_first, input int exp_done, input int glitch_n);
    int         beats;
    int         done_n;
    int         done_cnt;
    int         busy_cnt;
    int         first_n;
    logic [7:0] prev_data;
    logic       prev_last;
    logic       prev_stall;
    logic [5:0] bp;
    bp         = 6'b101001;
    beats      = 0;
    done_n     = -1;
    done_cnt   = 0;
    busy_cnt   = 0;
    first_n    = -1;
    prev_data  = '0;
    prev_last  = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    start          = 1'b1;
    base_addr      = base;
    length         = len;
    bus.out_ready  = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      start = (n == glitch_n);
      if (n == glitch_n) begin
        base_addr = 3'd0;
        length    = 4'd3;
      end
      bus.out_ready = bp_mode ? bp[(n - 1) % 6] : 1'b1;
      if (prev_stall) begin
        check({tag, "_stall_data"}, {24'h0, bus.out_data}, {24'h0, prev_data});
        check({tag, "_stall_last"}, {31'h0, bus.out_last}, {31'h0, prev_last});
      end
      if (bus.out_valid && first_n < 0) first_n = n;
      if (bus.out_valid && bus.out_ready) begin
        if (beats < 8) begin
          check($sformatf("%s_data%0d", tag, beats), {24'h0, bus.out_data},
                {24'h0, exp_beats[beats*8 +: 8]});
          check($sformatf("%s_last%0d", tag, beats), {31'h0, bus.out_last},
                (beats == int'(len) - 1) ? 32'd1 : 32'd0);
        end
        beats++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (done_n >= 0 && n > done_n) begin
        check({tag, "_post_idle"}, {30'h0, busy, bus.out_valid}, 32'd0);
      end
      if (done_n >= 0 && n == done_n + 4) break;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, (done_n >= 0) ? 32'd1 : 32'd0, 32'd1);
    check({tag, "_beats"}, beats, {28'h0, len});
    check({tag, "_done_cnt"}, done_cnt, 32'd1);
    if (exp_first >= 0) check({tag, "_first"}, first_n, exp_first);
    if (exp_done >= 0) begin
      check({tag, "_done_cyc"}, done_n, exp_done);
      check({tag, "_busy_cyc"}, busy_cnt, exp_done);
    end
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    base_addr     = '0;
    length        = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outs", {bus.out_data, 5'b0, bus.rom_addr, 4'b0, busy, done,
                       bus.out_valid, bus.out_last}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outs", {28'h0, busy, done, bus.out_valid, bus.out_last}, 32'd0);

    xfer("basic", 3'd0, 4'd5, 1'b0, 64'h00000004_03020100, 3, 9, 0);
    xfer("wrap",  3'd6, 4'd4, 1'b0, 64'h00000000_01000706, 3, 8, 0);
    xfer("bp",    3'd2, 4'd4, 1'b1, 64'h00000000_05040302, 3, 12, 0);
    xfer("len0",  3'd5, 4'd0, 1'b0, 64'h0, -1, 2, 0);
    xfer("len8",  3'd3, 4'd8, 1'b0, 64'h02010007_06050403, 3, 12, 0);
    xfer("ign",   3'd7, 4'd5, 1'b0, 64'h00000003_02010007, 3, 9, 2);

    // Reset after two beats of a length-6 transfer.
    @(negedge clk);
    start     = 1'b1;
    base_addr = 3'd0;
    length    = 4'd6;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 3) check("rmid_beat0", {24'h0, bus.out_data}, 32'h00);
      if (n == 4) check("rmid_beat1", {24'h0, bus.out_data}, 32'h01);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rmid_outs", {bus.out_data, 5'b0, bus.rom_addr, 4'b0, busy, done,
                        bus.out_valid, bus.out_last}, 32'd0);
    reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("rmid_quiet", {29'h0, busy, done, bus.out_valid}, 32'd0);
    end
    xfer("after_rst", 3'd1, 4'd2, 1'b0, 64'h00000000_00000201, 3, 6, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Initiator-side reader for the synchronous VRom model: walks a programmable address range, drives the ROM address and captures the registered read data.
- Presents the words as a valid/ready stream with full backpressure support.
- Sits between a VRom instance and any consumer that needs ROM contents streamed in order, for example table loaders or microcode fetch.

Parameters:
- ADDR_WIDTH, 3: ROM address width; the ROM has 2^ADDR_WIDTH words.
- DATA_WIDTH, 8: ROM word width.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle request to begin a transfer; sampled only in IDLE.
- base_addr, input, ADDR_WIDTH: first ROM address; captured when start is accepted.
- length, input, ADDR_WIDTH+1: number of words, 0..2^ADDR_WIDTH; captured when start is accepted.
- rom_addr, output, ADDR_WIDTH: address to VRom.
- rom_data, input, DATA_WIDTH: VRom read data; valid the cycle after rom_addr is sampled.
- out_data, output, DATA_WIDTH: streamed word.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: consumer accepts; a beat transfers when out_valid && out_ready at the rising edge.
- out_last, output, 1: qualifies the final beat of the transfer.
- busy, output, 1: high from start acceptance until the done cycle inclusive.
- done, output, 1: one-cycle pulse after the last beat transfers, or after a zero-length start.

Behaviour:
- Reset values:
  - rom_addr=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
  - Buffer empty, in-flight flag clear, FSM=IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 captures base_addr and length, sets busy the next cycle.
  - length=0 goes to DONE; otherwise goes to RUN.
- RUN: issues one read per cycle while the issue condition holds. Each issue:
  - drives rom_addr = next address;
  - sets the in-flight flag for the following cycle;
  - increments the address modulo 2^ADDR_WIDTH (wrap from 2^ADDR_WIDTH-1 to 0);
  - decrements the remaining-issue count.
  - When the remaining count reaches 0, go to DRAIN.
- Issue condition: (buffer_count + inflight - pop) < 2, where pop = out_valid && out_ready. This guarantees the captured word always has a free slot.
- Capture: in the cycle after an issue, rom_data is written into a 2-entry FIFO; out_data/out_valid come from the FIFO head.
- Throughput: with out_ready held high, 1 word per cycle after initial latency.
- Latency: start accepted at edge E0 gives first issue in the cycle after E0. The first out_valid appears 2 cycles after the issue cycle (ROM sample, then FIFO write).
- rom_addr holds its last value when not issuing.
- out_last=1 exactly on the beat whose sequence index equals length-1. It is held with its data under backpressure.
- DRAIN: no issues. When the last beat transfers, go to DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0.
- start while not IDLE is ignored, with no effect on the current transfer.
- out_data and out_last are stable while out_valid=1 and out_ready=0.
- length=2^ADDR_WIDTH reads every word once, starting at base_addr and wrapping.
- Reset mid-transfer:
  - next cycle all outputs are at reset values;
  - FIFO and in-flight flag are cleared;
  - rom_data returned for a pre-reset issue is discarded;
  - no done pulse.

Test Plan:
ROM preloaded with data[a]=a, ADDR_WIDTH=3, DATA_WIDTH=8.
- Basic: start, base=0, length=5, out_ready=1 -> beats 00,01,02,03,04 on consecutive cycles; out_last only on 04; done pulse one cycle after the 04 transfer; busy then falls.
- Wrap: base=6, length=4 -> beats 06,07,00,01; out_last on 01.
- Backpressure: base=2, length=4, out_ready toggling 1,0,0,1,0,1,... -> beats 02..05 in order, none lost or duplicated; out_data stable while stalled; FIFO never overflows (assertion on write to a full FIFO).
- Edge lengths:
  - length=0 -> no out_valid; done pulses 1 cycle after DONE entry; busy high 2 cycles.
  - length=8, base=3 -> 03..07,00..02 with out_last on 02.
- Ignored start: start pulsed during a length=5 transfer with base=7 -> original sequence unaffected; no second transfer.
- Reset mid-operation: assert reset after 2 beats of a length=6 transfer -> next cycle out_valid=0, busy=0, done never pulses; new start base=1, length=2 then yields 01,02 only.
